// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: arbitrates memory wait, pending redirect,
// decode hazard, decode branch and fetch wait into per-stage hold/bubble
// controls and a PC redirect. Also runs a memory-wait watchdog and
// saturating performance counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | no data-memory wait in progress, wait counter held at zero
//   MEM_WAIT | data memory busy since last cycle, wait counter advancing
//
// Bit mapping of stall/flush: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_stall_req,
   input  logic             id_branch_taken,
   input  logic [31:0]      id_branch_target,
   input  logic             if_busy,
   input  logic             mem_busy,
   output logic [4:0]       stall,
   output logic [4:0]       flush,
   output logic             pc_redirect,
   output logic [31:0]      redirect_target,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] TO_VAL = WC_W'(MEM_TIMEOUT);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_pend_valid;
   logic [31:0]       r_pend_target;
   logic [WC_W-1:0]   r_wait_cnt;
   logic [WC_W-1:0]   w_wait_nxt;
   logic              r_mem_timeout;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic [CNT_W-1:0]  r_redirect_count;

   // Zero-latency priority arbitration; reset forces bubbles everywhere.
   always_comb begin
      stall           = 5'b00000;
      flush           = 5'b00000;
      pc_redirect     = 1'b0;
      redirect_target = 32'h0;
      if (!rst_n) begin
         flush = 5'b11111;
      end else if (mem_busy) begin
         stall = 5'b01111;
         flush = 5'b10000;
      end else if (r_pend_valid) begin
         // Deferred redirect wins over a hazard stall; stall re-evaluates next cycle.
         pc_redirect     = 1'b1;
         redirect_target = r_pend_target;
         flush           = 5'b00010;
      end else if (id_stall_req) begin
         stall = 5'b00011;
         flush = 5'b00100;
      end else if (id_branch_taken) begin
         pc_redirect     = 1'b1;
         redirect_target = id_branch_target;
         flush           = 5'b00010;
      end else if (if_busy) begin
         stall = 5'b00001;
         flush = 5'b00010;
      end
   end

   // Next state and next wait count; state only affects the watchdog.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         RUN: begin
            w_wait_nxt = '0;
            if (mem_busy) w_state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_busy && (r_wait_cnt != TO_VAL)) w_wait_nxt = r_wait_cnt + 1'b1;
            if (!mem_busy) w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // State register, watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_wait_nxt == TO_VAL) r_mem_timeout <= 1'b1;
      end
   end

   // Hold a branch resolved during a memory wait until the wait ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_valid  <= 1'b0;
         r_pend_target <= 32'h0;
      end else if (mem_busy) begin
         if (id_branch_taken && !r_pend_valid) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= id_branch_target;
         end
      end else if (r_pend_valid) begin
         r_pend_valid <= 1'b0;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles   <= '0;
         r_redirect_count <= '0;
      end else begin
         if (stall[0] && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (pc_redirect && (r_redirect_count != '1)) r_redirect_count <= r_redirect_count + 1'b1;
      end
   end

   assign mem_timeout    = r_mem_timeout;
   assign stall_cycles   = r_stall_cycles;
   assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, hand sequences for multi-cycle corners,
// then randomized traffic against a behavioural model.
module tb_pipe_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             id_stall_req;
   logic             id_branch_taken;
   logic [31:0]      id_branch_target;
   logic             if_busy;
   logic             mem_busy;
   logic [4:0]       stall;
   logic [4:0]       flush;
   logic             pc_redirect;
   logic [31:0]      redirect_target;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] redirect_count;

   int n_cmp;
   int n_err;

   pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_stall_req     (id_stall_req),
      .id_branch_taken  (id_branch_taken),
      .id_branch_target (id_branch_target),
      .if_busy          (if_busy),
      .mem_busy         (mem_busy),
      .stall            (stall),
      .flush            (flush),
      .pc_redirect      (pc_redirect),
      .redirect_target  (redirect_target),
      .mem_timeout      (mem_timeout),
      .stall_cycles     (stall_cycles),
      .redirect_count   (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sr;
      logic        br;
      logic [31:0] tgt;
      logic        ib;
      logic        mb;
      logic [4:0]  e_stall;
      logic [4:0]  e_flush;
      logic        e_redir;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic sr, input logic br, input logic [31:0] tgt,
                         input logic ib, input logic mb);
      id_stall_req     = sr;
      id_branch_taken  = br;
      id_branch_target = tgt;
      if_busy          = ib;
      mem_busy         = mb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 32'h0, 0, 0);
      rst_n = 1'b0;
      #3;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_comb(input string name, input logic [4:0] es, input logic [4:0] ef,
                           input logic er);
      check({name, ".stall"}, 32'(stall), 32'(es));
      check({name, ".flush"}, 32'(flush), 32'(ef));
      check({name, ".redir"}, 32'(pc_redirect), 32'(er));
   endtask

   // Behavioural reference state for the random phase.
   int          m_stall_cnt;
   int          m_redir_cnt;
   logic [31:0] m_pend_q[$];

   initial begin
      logic [4:0]  es;
      logic [4:0]  ef;
      logic        er;
      logic [31:0] et;
      logic        sr, br, ib, mb;
      logic [31:0] tgt;
      int          busy_run;

      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_in(0, 0, 32'h0, 0, 0);

      vecs[0] = '{0, 0, 32'h0,   0, 0, 5'b00000, 5'b00000, 0, 32'h0};
      vecs[1] = '{0, 0, 32'h0,   1, 0, 5'b00001, 5'b00010, 0, 32'h0};
      vecs[2] = '{1, 1, 32'h44,  1, 0, 5'b00011, 5'b00100, 0, 32'h0};
      vecs[3] = '{0, 1, 32'h40,  1, 0, 5'b00000, 5'b00010, 1, 32'h40};
      vecs[4] = '{0, 1, 32'h80,  0, 1, 5'b01111, 5'b10000, 0, 32'h0};
      vecs[5] = '{1, 1, 32'h100, 1, 1, 5'b01111, 5'b10000, 0, 32'h0};
      vecs[6] = '{1, 1, 32'h200, 0, 0, 5'b00000, 5'b00010, 1, 32'h80};
      vecs[7] = '{1, 0, 32'h0,   0, 0, 5'b00011, 5'b00100, 0, 32'h0};
      vecs[8] = '{0, 0, 32'h0,   0, 0, 5'b00000, 5'b00000, 0, 32'h0};

      // Reset values while held in reset
      #2;
      chk_comb("por", 5'b00000, 5'b11111, 1'b0);
      check("por.timeout", 32'(mem_timeout), 32'h0);
      check("por.stall_cycles", 32'(stall_cycles), 32'h0);
      tick();
      rst_n = 1'b1;

      // Vector table
      foreach (vecs[i]) begin
         set_in(vecs[i].sr, vecs[i].br, vecs[i].tgt, vecs[i].ib, vecs[i].mb);
         @(negedge clk);
         chk_comb($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_redir);
         if (vecs[i].e_redir)
            check($sformatf("vec%0d.target", i), redirect_target, vecs[i].e_tgt);
         tick();
      end
      @(negedge clk);
      check("vec.stall_cycles", 32'(stall_cycles), 32'd5);
      check("vec.redirect_count", 32'(redirect_count), 32'd2);

      // Reset asserted mid-stream
      set_in(1, 1, 32'h55, 1, 1);
      rst_n = 1'b0;
      #1;
      chk_comb("mid_rst", 5'b00000, 5'b11111, 1'b0);
      check("mid_rst.stall_cycles", 32'(stall_cycles), 32'h0);
      check("mid_rst.redirect_count", 32'(redirect_count), 32'h0);
      check("mid_rst.timeout", 32'(mem_timeout), 32'h0);
      tick();
      set_in(0, 0, 32'h0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_comb("post_rst", 5'b00000, 5'b00000, 1'b0);

      // Two-cycle decode stall
      do_reset();
      for (int c = 0; c < 2; c++) begin
         set_in(1, 0, 32'h0, 0, 0);
         @(negedge clk);
         chk_comb($sformatf("hz%0d", c), 5'b00011, 5'b00100, 1'b0);
         tick();
      end
      set_in(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      check("hz.stall_cycles", 32'(stall_cycles), 32'd2);

      // Single decode branch
      do_reset();
      set_in(0, 1, 32'h40, 0, 0);
      @(negedge clk);
      chk_comb("br", 5'b00000, 5'b00010, 1'b1);
      check("br.target", redirect_target, 32'h40);
      tick();
      set_in(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      check("br.redirect_count", 32'(redirect_count), 32'd1);

      // Branch during memory wait, second branch ignored
      do_reset();
      for (int c = 1; c <= 3; c++) begin
         if (c == 1) set_in(0, 1, 32'h80, 0, 1);
         else if (c == 2) set_in(0, 1, 32'h100, 0, 1);
         else set_in(0, 0, 32'h0, 0, 1);
         @(negedge clk);
         chk_comb($sformatf("mw%0d", c), 5'b01111, 5'b10000, 1'b0);
         tick();
      end
      set_in(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      check("mw4.redir", 32'(pc_redirect), 32'h1);
      check("mw4.target", redirect_target, 32'h80);
      tick();
      @(negedge clk);
      check("mw5.redir", 32'(pc_redirect), 32'h0);

      // Watchdog: sticky until reset
      do_reset();
      set_in(0, 0, 32'h0, 0, 1);
      for (int c = 1; c <= 3; c++) tick();
      @(negedge clk);
      check("wd.early", 32'(mem_timeout), 32'h0);
      for (int c = 4; c <= 6; c++) tick();
      @(negedge clk);
      check("wd.set", 32'(mem_timeout), 32'h1);
      chk_comb("wd.busy", 5'b01111, 5'b10000, 1'b0);
      set_in(0, 0, 32'h0, 0, 0);
      tick();
      tick();
      @(negedge clk);
      check("wd.sticky", 32'(mem_timeout), 32'h1);
      rst_n = 1'b0;
      #1;
      check("wd.cleared", 32'(mem_timeout), 32'h0);
      tick();
      rst_n = 1'b1;

      // Pending redirect discarded by reset
      do_reset();
      set_in(0, 1, 32'h300, 0, 1);
      tick();
      set_in(0, 0, 32'h0, 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      set_in(0, 0, 32'h0, 0, 0);
      tick();
      @(negedge clk);
      check("prst.redir", 32'(pc_redirect), 32'h0);
      tick();
      @(negedge clk);
      check("prst.redir2", 32'(pc_redirect), 32'h0);
      check("prst.redirect_count", 32'(redirect_count), 32'h0);

      // Counter saturation
      do_reset();
      set_in(1, 0, 32'h0, 0, 0);
      for (int c = 0; c < 20; c++) tick();
      set_in(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      check("sat.stall_cycles", 32'(stall_cycles), 32'hF);

      // Randomized traffic against the behavioural model
      do_reset();
      m_stall_cnt = 0;
      m_redir_cnt = 0;
      m_pend_q.delete();
      busy_run = 0;
      for (int c = 0; c < 400; c++) begin
         // Busy bursts kept below the watchdog limit so mem_timeout stays clear.
         mb  = (busy_run < 3) ? ($urandom_range(0, 2) == 0) : 1'b0;
         sr  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 1) == 0);
         ib  = ($urandom_range(0, 2) == 0);
         tgt = $urandom;
         set_in(sr, br, tgt, ib, mb);

         es = 5'b00000; ef = 5'b00000; er = 1'b0; et = 32'h0;
         if (mb) begin
            es = 5'b01111; ef = 5'b10000;
         end else if (m_pend_q.size() != 0) begin
            ef = 5'b00010; er = 1'b1; et = m_pend_q[0];
         end else if (sr) begin
            es = 5'b00011; ef = 5'b00100;
         end else if (br) begin
            ef = 5'b00010; er = 1'b1; et = tgt;
         end else if (ib) begin
            es = 5'b00001; ef = 5'b00010;
         end

         @(negedge clk);
         chk_comb($sformatf("rnd%0d", c), es, ef, er);
         if (er) check($sformatf("rnd%0d.target", c), redirect_target, et);
         check($sformatf("rnd%0d.stall_cycles", c), 32'(stall_cycles), 32'(m_stall_cnt));
         check($sformatf("rnd%0d.redirect_count", c), 32'(redirect_count), 32'(m_redir_cnt));
         check($sformatf("rnd%0d.timeout", c), 32'(mem_timeout), 32'h0);

         if (es[0]) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
         if (er) m_redir_cnt = (m_redir_cnt < CNT_MAX) ? m_redir_cnt + 1 : CNT_MAX;
         if (mb) begin
            if (br && m_pend_q.size() == 0) m_pend_q.push_back(tgt);
         end else if (m_pend_q.size() != 0) begin
            void'(m_pend_q.pop_front());
         end
         busy_run = mb ? busy_run + 1 : 0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
